// File: rtl/pipelined_subtractor.sv
// Three-stage gpk carry-lookahead subtractor (a - b) with valid/ready handshake and registered outputs.
// Defining SUB_OVERFLOW_EN adds the signed-overflow pipeline; otherwise ovf is tied to 0.
module pipelined_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  localparam int HALF = WIDTH / 2;

  logic             stall_s;
  logic             s1_valid_r, s2_valid_r, s3_valid_r;
  logic [WIDTH-1:0] s1_a_r, s1_nb_r;
  logic [WIDTH-1:0] gen_s, prop_s, sum_s;
  logic [HALF:0]    lo_c_s, hi0_c_s, hi1_c_s;
  logic [HALF-1:0]  s2_lo_c_r;
  logic             s2_lo_gen_r;
  logic [HALF:0]    s2_hi0_c_r, s2_hi1_c_r;
  logic [WIDTH-1:0] s2_sum_r, s3_sum_r;
  logic [WIDTH:0]   carry_s, s3_carry_r;
  logic [WIDTH-1:0] diff_s;

  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;

  // Valid bits: the whole pipeline advances together unless the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s3_valid_r <= 1'b0;
      out_valid  <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= in_valid;
      s2_valid_r <= s1_valid_r;
      s3_valid_r <= s2_valid_r;
      out_valid  <= s3_valid_r;
    end
  end

  // S1: capture minuend and inverted subtrahend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_r  <= '0;
      s1_nb_r <= '0;
    end else if (!stall_s && in_valid) begin
      s1_a_r  <= a;
      s1_nb_r <= ~b;
    end
  end

  // g where both bits are 1, p where exactly one is; otherwise kill.
  assign gen_s  = s1_a_r & s1_nb_r;
  assign prop_s = s1_a_r ^ s1_nb_r;
  assign sum_s  = s1_a_r ^ s1_nb_r;

  // Half-width ripple of gpk labels; upper half evaluated for both possible carry-ins.
  always_comb begin
    lo_c_s     = '0;
    hi0_c_s    = '0;
    hi1_c_s    = '0;
    lo_c_s[0]  = 1'b1;
    hi0_c_s[0] = 1'b0;
    hi1_c_s[0] = 1'b1;
    for (int i = 0; i < HALF; i++) begin
      lo_c_s[i+1]  = gen_s[i] | (prop_s[i] & lo_c_s[i]);
      hi0_c_s[i+1] = gen_s[HALF+i] | (prop_s[HALF+i] & hi0_c_s[i]);
      hi1_c_s[i+1] = gen_s[HALF+i] | (prop_s[HALF+i] & hi1_c_s[i]);
    end
  end

  // S2: register half carries, lower-half group carry-out and initial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_lo_c_r   <= '0;
      s2_lo_gen_r <= 1'b0;
      s2_hi0_c_r  <= '0;
      s2_hi1_c_r  <= '0;
      s2_sum_r    <= '0;
    end else if (!stall_s && s1_valid_r) begin
      s2_lo_c_r   <= lo_c_s[HALF-1:0];
      s2_lo_gen_r <= lo_c_s[HALF];
      s2_hi0_c_r  <= hi0_c_s;
      s2_hi1_c_r  <= hi1_c_s;
      s2_sum_r    <= sum_s;
    end
  end

  // Upper carries corrected by the lower group's carry-out.
  assign carry_s = {(s2_lo_gen_r ? s2_hi1_c_r : s2_hi0_c_r), s2_lo_c_r};

  // S3: register the full carry vector with its sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_sum_r   <= '0;
      s3_carry_r <= '0;
    end else if (!stall_s && s2_valid_r) begin
      s3_sum_r   <= s2_sum_r;
      s3_carry_r <= carry_s;
    end
  end

  assign diff_s = s3_sum_r ^ s3_carry_r[WIDTH-1:0];

  // Output registers; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (!stall_s && s3_valid_r) begin
      diff   <= diff_s;
      borrow <= ~s3_carry_r[WIDTH];
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic s2_a_sign_r, s2_b_sign_r, s3_a_sign_r, s3_b_sign_r;

  // Sign bits travel alongside their operands so ovf lines up with diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_a_sign_r <= 1'b0;
      s2_b_sign_r <= 1'b0;
      s3_a_sign_r <= 1'b0;
      s3_b_sign_r <= 1'b0;
      ovf         <= 1'b0;
    end else if (!stall_s) begin
      if (s1_valid_r) begin
        s2_a_sign_r <= s1_a_r[WIDTH-1];
        s2_b_sign_r <= ~s1_nb_r[WIDTH-1];
      end
      if (s2_valid_r) begin
        s3_a_sign_r <= s2_a_sign_r;
        s3_b_sign_r <= s2_b_sign_r;
      end
      if (s3_valid_r) begin
        ovf <= (s3_a_sign_r != s3_b_sign_r) && (diff_s[WIDTH-1] != s3_a_sign_r);
      end
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
